hilo_unit: RTL

- Downstream consumer of the pipelined multiplier (and the divider): holds the architectural HI/LO registers.
- Tracks the single outstanding MULT/MULTU/DIV/DIVU and commits its result when the unit's done pulse arrives.
- Services MTHI/MTLO writes and MFHI/MFLO reads, with a bypass on the commit cycle and a stall while a result is pending.
- Sits between the execute-stage mul/div units and writeback; the issue logic sees back-pressure via issue_ready and mf_stall/mt_stall.

---
 rtl/hilo_unit_pkg.sv | 30 +++
 rtl/hilo_unit_watchdog.sv | 23 ++
 rtl/hilo_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared execute-stage definitions: ALU op codes plus the HI/LO unit's
// state encoding and register-select constants.
package hilo_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam int HILO_DATA_W = 32;

  // HI/LO unit FSM encoding
  localparam logic [1:0] HILO_ST_IDLE     = 2'd0;
  localparam logic [1:0] HILO_ST_WAIT_MUL = 2'd1;
  localparam logic [1:0] HILO_ST_WAIT_DIV = 2'd2;

  localparam logic HILO_SEL_HI = 1'b0;
  localparam logic HILO_SEL_LO = 1'b1;

endpackage

// File: rtl/hilo_unit_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting for a mul/div result and
// flags when the budget is exhausted.
module hilo_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  always_ff @(posedge clk) begin
    if (reset || clear || start) cnt <= '0;
    else if (run)                cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers: commits the single outstanding mul/div result,
// services MTHI/MTLO and MFHI/MFLO with commit-cycle bypass and pending stall.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int DATA_W  = HILO_DATA_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  output logic              issue_ready,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  input  logic              mt_valid,
  input  logic              mt_sel,
  input  logic [DATA_W-1:0] mt_data,
  output logic              mt_stall,
  input  logic              mf_req,
  input  logic              mf_sel,
  output logic [DATA_W-1:0] mf_data,
  output logic              mf_stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              timeout_err
);

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_pair_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic             in_wait, mul_hit, div_hit, hit, abort;
  hilo_pair_t       res;

  assign in_wait = (state != HILO_ST_IDLE);
  assign mul_hit = (state == HILO_ST_WAIT_MUL) && mul_done;
  assign div_hit = (state == HILO_ST_WAIT_DIV) && div_done;
  assign hit     = mul_hit || div_hit;
  assign abort   = in_wait && !hit && expire;
  assign res     = mul_hit ? '{hi: mul_hi, lo: mul_lo} : '{hi: div_hi, lo: div_lo};

  hilo_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .start  (!in_wait && issue_valid),
    .run    (in_wait && !hit && !expire),
    .cnt    (cnt),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HILO_ST_IDLE;
      hi          <= '0;
      lo          <= '0;
      timeout_err <= 1'b0;
    end else if (flush) begin
      // a done arriving alongside flush belongs to the squashed op
      state       <= HILO_ST_IDLE;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if (!in_wait) begin
        // MT is older than a same-cycle issue, so both take effect
        if (mt_valid) begin
          if (mt_sel == HILO_SEL_LO) lo <= mt_data;
          else                       hi <= mt_data;
        end
        if (issue_valid)
          state <= issue_is_div ? HILO_ST_WAIT_DIV : HILO_ST_WAIT_MUL;
      end else if (hit) begin
        hi    <= res.hi;
        lo    <= res.lo;
        state <= HILO_ST_IDLE;
      end else if (expire) begin
        state <= HILO_ST_IDLE;
      end
    end
  end

  assign busy        = in_wait;
  assign issue_ready = !in_wait;
  assign mt_stall    = mt_valid && in_wait;

  always_comb begin
    mf_data  = (mf_sel == HILO_SEL_LO) ? lo : hi;
    mf_stall = 1'b0;
    if (hit)
      mf_data = (mf_sel == HILO_SEL_LO) ? res.lo : res.hi;
    else if (in_wait)
      mf_stall = mf_req;
  end

  ap_issue_when_ready: assert property (@(posedge clk) disable iff (reset)
    !(issue_valid && !issue_ready))
    else $error("issue_valid while hilo_unit busy");

endmodule
